// File: rtl/seg_display_scheduler_if.sv
// Digit-write request bundle shared by the two front-end requesters and the display scheduler.
// Bit/field i of each vector belongs to requester i.
interface seg_display_scheduler_if;
    logic [1:0] req_valid;
    logic [5:0] req_sel;
    logic [7:0] req_data;
    logic [1:0] req_ready;

    // A write is taken on a rising edge where req_valid[i] & req_ready[i]; a requester holds
    // valid/sel/data stable until it sees ready, and ready never looks at sel or data.
    modport master (
        output req_valid,
        output req_sel,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_sel,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/seg_display_scheduler.sv
// Owns the 8x4-bit digit store: round-robin write arbitration, sequenced clear,
// prescaled anode multiplexing and registered hex-to-seven-segment decoding.
module seg_display_scheduler #(
    parameter int CLK_DIV   = 131072,
    parameter bit HOLD_SCAN = 1'b0
) (
    input  logic                          clk,
    input  logic                          reset,
    seg_display_scheduler_if.slave        req,
    input  logic                          clear_start,
    output logic                          clear_busy,
    input  logic [7:0]                    blank_mask,
    output logic [2:0]                    scan_idx,
    output logic [7:0]                    anode,
    output logic [6:0]                    cathodes
);

    localparam int            PW       = $clog2(CLK_DIV);
    localparam logic [PW-1:0] DIV_LAST = PW'(CLK_DIV - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [2:0]    r_clear_idx;
    logic [2:0]    w_clear_idx_nxt;

    logic [3:0]    r_mem [8];
    logic          r_rr_ptr;
    logic [PW-1:0] r_presc;
    logic [2:0]    r_scan_idx;
    logic [7:0]    r_anode;
    logic [6:0]    r_cathodes;

    logic [1:0]    w_grant;
    logic          w_wr_en;
    logic [2:0]    w_wr_sel;
    logic [3:0]    w_wr_data;
    logic          w_tick;
    logic          w_scan_hold;
    logic [3:0]    w_cur_digit;
    logic [7:0]    w_anode_nxt;
    logic [6:0]    w_cathodes_nxt;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b0000001;
            4'h1:    s = 7'b1001111;
            4'h2:    s = 7'b0010010;
            4'h3:    s = 7'b0000110;
            4'h4:    s = 7'b1001100;
            4'h5:    s = 7'b0100100;
            4'h6:    s = 7'b0100000;
            4'h7:    s = 7'b0001111;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0000100;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b1100000;
            4'hC:    s = 7'b0110001;
            4'hD:    s = 7'b1000010;
            4'hE:    s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_clear_idx <= 3'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_clear_idx <= w_clear_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_clear_idx_nxt = r_clear_idx;
        case (r_state)
            ST_IDLE: begin
                if (clear_start) begin
                    w_state_nxt     = ST_CLEAR;
                    w_clear_idx_nxt = 3'd0;
                end
            end
            ST_CLEAR: begin
                w_clear_idx_nxt = r_clear_idx + 3'd1;
                if (r_clear_idx == 3'd7) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Grants are withheld during CLEAR and while reset is held, so no write can race the clear.
    always_comb begin
        w_grant = 2'b00;
        if (!reset && (r_state == ST_IDLE)) begin
            case (req.req_valid)
                2'b01:   w_grant = 2'b01;
                2'b10:   w_grant = 2'b10;
                2'b11:   w_grant = r_rr_ptr ? 2'b10 : 2'b01;
                default: w_grant = 2'b00;
            endcase
        end
    end

    assign req.req_ready = w_grant;
    assign w_wr_en       = |w_grant;
    assign w_wr_sel      = w_grant[1] ? req.req_sel[5:3]  : req.req_sel[2:0];
    assign w_wr_data     = w_grant[1] ? req.req_data[7:4] : req.req_data[3:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int d = 0; d < 8; d++) begin
                r_mem[d] <= 4'h0;
            end
        end else if (r_state == ST_CLEAR) begin
            r_mem[r_clear_idx] <= 4'h0;
        end else if (w_wr_en) begin
            r_mem[w_wr_sel] <= w_wr_data;
        end
    end

    // After serving requester i the other one gets priority on the next contention.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr <= 1'b0;
        end else if (w_wr_en) begin
            r_rr_ptr <= w_grant[0];
        end
    end

    assign w_tick      = (r_presc == DIV_LAST);
    assign w_scan_hold = HOLD_SCAN && (r_state == ST_CLEAR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc    <= '0;
            r_scan_idx <= 3'd0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (w_tick && !w_scan_hold) begin
                r_scan_idx <= r_scan_idx + 3'd1;
            end
        end
    end

    assign w_cur_digit    = r_mem[r_scan_idx];
    assign w_anode_nxt    = blank_mask[r_scan_idx] ? 8'hFF : ~(8'h01 << r_scan_idx);
    assign w_cathodes_nxt = seg_decode(w_cur_digit);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_anode    <= 8'hFF;
            r_cathodes <= 7'h7F;
        end else begin
            r_anode    <= w_anode_nxt;
            r_cathodes <= w_cathodes_nxt;
        end
    end

    assign anode      = r_anode;
    assign cathodes   = r_cathodes;
    assign scan_idx   = r_scan_idx;
    assign clear_busy = (r_state == ST_CLEAR);

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Randomized bench for seg_display_scheduler: a cycle-level reference model predicts every
// output sample; a negedge monitor pops the predictions and compares them with the DUT.
module tb_seg_display_scheduler;

    localparam int CLK_DIV = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear_start;
    logic       clear_busy;
    logic [7:0] blank_mask;
    logic [2:0] scan_idx;
    logic [7:0] anode;
    logic [6:0] cathodes;

    seg_display_scheduler_if bus ();

    seg_display_scheduler #(
        .CLK_DIV   (CLK_DIV),
        .HOLD_SCAN (1'b0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (bus),
        .clear_start (clear_start),
        .clear_busy  (clear_busy),
        .blank_mask  (blank_mask),
        .scan_idx    (scan_idx),
        .anode       (anode),
        .cathodes    (cathodes)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // {anode[8], cathodes[7], scan_idx[3], clear_busy[1], req_ready[2]}
    logic [20:0] exp_q[$];
    logic [20:0] mon_e;

    // Stimulus state applied on the next step
    logic       n_reset;
    logic       n_clear;
    logic [7:0] n_blank;
    logic [1:0] pend;
    logic [2:0] p_sel  [2];
    logic [3:0] p_data [2];

    // Reference model: digit contents, arbitration priority, clear progress, time since reset
    logic [6:0] seg_tab [16];
    logic [3:0] m_mem [8];
    logic       m_ptr;
    int         m_left;
    int         m_cyc;
    logic [7:0] d_an;
    logic [6:0] d_ca;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("anode",      anode,                   mon_e[20:13]);
            chk("cathodes",   {1'b0, cathodes},        {1'b0, mon_e[12:6]});
            chk("scan_idx",   {5'd0, scan_idx},        {5'd0, mon_e[5:3]});
            chk("clear_busy", {7'd0, clear_busy},      {7'd0, mon_e[2]});
            chk("req_ready",  {6'd0, bus.req_ready},   {6'd0, mon_e[1:0]});
        end
    end

    task automatic model_reset();
        for (int d = 0; d < 8; d++) m_mem[d] = 4'h0;
        m_ptr  = 1'b0;
        m_left = 0;
        m_cyc  = 0;
        d_an   = 8'hFF;
        d_ca   = 7'h7F;
    endtask

    // One clock: drive inputs just after the edge, predict this cycle's samples, then
    // advance the model across the following edge.
    task automatic step();
        logic [1:0] g;
        logic       busy;
        logic [2:0] sc;
        int         w;
        @(posedge clk);
        #1;
        reset         = n_reset;
        clear_start   = n_clear;
        blank_mask    = n_blank;
        bus.req_valid = pend;
        bus.req_sel   = {p_sel[1], p_sel[0]};
        bus.req_data  = {p_data[1], p_data[0]};
        if (n_reset) begin
            model_reset();
            exp_q.push_back({8'hFF, 7'h7F, 3'd0, 1'b0, 2'b00});
        end else begin
            busy = (m_left != 0);
            sc   = 3'((m_cyc / CLK_DIV) % 8);
            g    = busy ? 2'b00 : ((pend == 2'b11) ? (m_ptr ? 2'b10 : 2'b01) : pend);
            exp_q.push_back({d_an, d_ca, sc, busy, g});
            d_an = n_blank[sc] ? 8'hFF : (8'hFF ^ (8'h01 << sc));
            d_ca = seg_tab[m_mem[sc]];
            if (busy) begin
                m_mem[8 - m_left] = 4'h0;
                m_left--;
            end else begin
                if (g != 2'b00) begin
                    w = g[1] ? 1 : 0;
                    m_mem[p_sel[w]] = p_data[w];
                    m_ptr   = (w == 0);
                    pend[w] = 1'b0;
                end
                if (n_clear) m_left = 8;
            end
            m_cyc++;
        end
        n_clear = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic write1(input int i, input logic [2:0] s, input logic [3:0] d);
        int n;
        n         = 0;
        pend[i]   = 1'b1;
        p_sel[i]  = s;
        p_data[i] = d;
        while (pend[i] && n < 50) begin
            step();
            n++;
        end
        if (pend[i]) begin
            tests++;
            fails++;
            $display("FAIL write_timeout: requester %0d not granted in %0d cycles", i, n);
            pend[i] = 1'b0;
        end
    endtask

    initial begin
        int c0;
        int c1;
        int n;
        seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        reset         = 1'b1;
        clear_start   = 1'b0;
        blank_mask    = 8'h00;
        bus.req_valid = 2'b00;
        bus.req_sel   = 6'd0;
        bus.req_data  = 8'd0;
        n_reset = 1'b1;
        n_clear = 1'b0;
        n_blank = 8'h00;
        pend    = 2'b00;
        for (int i = 0; i < 2; i++) begin
            p_sel[i]  = 3'd0;
            p_data[i] = 4'd0;
        end
        model_reset();

        // Reset and a full free-running scan
        idle(3);
        n_reset = 1'b0;
        idle(40);

        // Single requester, then watch digit 3 come round
        write1(0, 3'd3, 4'hA);
        idle(34);

        // Hand priority to requester 0, then sustained contention
        write1(1, 3'd5, 4'hC);
        c0 = 0;
        c1 = 0;
        n  = 0;
        pend      = 2'b11;
        p_sel[0]  = 3'd0;
        p_data[0] = 4'($urandom_range(0, 15));
        p_sel[1]  = 3'd4;
        p_data[1] = 4'($urandom_range(0, 15));
        while ((pend != 2'b00) && n < 100) begin
            step();
            n++;
            if (!pend[0] && c0 < 4) begin
                c0++;
                if (c0 < 4) begin
                    pend[0]   = 1'b1;
                    p_sel[0]  = 3'(c0);
                    p_data[0] = 4'($urandom_range(0, 15));
                end
            end
            if (!pend[1] && c1 < 4) begin
                c1++;
                if (c1 < 4) begin
                    pend[1]   = 1'b1;
                    p_sel[1]  = 3'(4 + c1);
                    p_data[1] = 4'($urandom_range(0, 15));
                end
            end
        end
        idle(36);

        // Fill with 8, clear, with both requesters waiting through the clear
        for (int s = 0; s < 8; s++) write1(0, 3'(s), 4'h8);
        idle(2);
        n_clear = 1'b1;
        step();
        pend      = 2'b11;
        p_sel[0]  = 3'd1;
        p_data[0] = 4'h5;
        p_sel[1]  = 3'd6;
        p_data[1] = 4'h9;
        n = 0;
        while ((pend != 2'b00) && n < 40) begin
            step();
            n++;
        end
        idle(36);

        // Blanking of slots 0 and 2
        n_blank = 8'h05;
        idle(40);
        n_blank = 8'h00;

        // Random traffic, clear pulses (some landing mid-clear) and mask changes
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i]   = 1'b1;
                    p_sel[i]  = 3'($urandom_range(0, 7));
                    p_data[i] = 4'($urandom_range(0, 15));
                end
            end
            if ($urandom_range(0, 39) == 0) n_clear = 1'b1;
            if ($urandom_range(0, 49) == 0) n_blank = 8'($urandom_range(0, 255));
            step();
        end
        pend    = 2'b00;
        n_blank = 8'h00;
        idle(12);

        // Asynchronous reset in the fourth clear cycle
        for (int s = 0; s < 8; s++) write1(0, 3'(s), 4'h3);
        n_clear = 1'b1;
        step();
        idle(3);
        n_reset = 1'b1;
        idle(3);
        n_reset = 1'b0;
        idle(40);

        @(negedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
